// File: rtl/mem_port_arbiter_if.sv
// Unified memory bus between the F/M port arbiter (master) and the memory
// slave. The slave answers with BusAck, together with BusRdata, in the last
// cycle of each request.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  BusReq;
  logic                  BusWe;
  logic [ADDR_WIDTH-1:0] BusAddr;
  logic [DATA_WIDTH-1:0] BusWdata;
  logic [DATA_WIDTH-1:0] BusRdata;
  logic                  BusAck;

  modport master (
    output BusReq, BusWe, BusAddr, BusWdata,
    input  BusRdata, BusAck
  );

  modport slave (
    input  BusReq, BusWe, BusAddr, BusWdata,
    output BusRdata, BusAck
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one unified instruction/data memory port between the fetch stage (F)
// and the memory stage (M). Each bus transaction is sequenced by a small
// IDLE/FETCH/DATA FSM. Data wins arbitration because it belongs to the older
// instruction. Fetches overtaken by a taken branch are completed on the bus
// and then discarded.
// Optional build macro ARB_STARVE_GUARD_EN: after MAX_DATA_RUN consecutive
// data grants made while a fetch was waiting, the next arbitration goes to
// fetch.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // fetch side
  input  logic                  IReqF,
  input  logic [ADDR_WIDTH-1:0] PCF,
  input  logic                  FetchAdvF,
  input  logic                  FlushF,
  output logic [DATA_WIDTH-1:0] IRdataF,
  output logic                  IValidF,
  output logic                  StallFetch,
  // memory-stage side
  input  logic                  DReqM,
  input  logic                  DWeM,
  input  logic [ADDR_WIDTH-1:0] DAddrM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] DRdataM,
  output logic                  DValidM,
  output logic                  StallMem,
  // unified memory bus
  mem_port_arbiter_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_bus_req;
  logic                  r_bus_we;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [DATA_WIDTH-1:0] r_bus_wdata;
  logic                  r_stale;
  logic                  r_idone;
  logic                  r_ddone;
  logic [DATA_WIDTH-1:0] r_irdata;
  logic [DATA_WIDTH-1:0] r_drdata;

  logic w_data_pend;
  logic w_fetch_pend;
  logic w_force_fetch;
  logic w_grant_data;
  logic w_grant_fetch;
  logic w_ack;

  // A data access already answered this cycle is not asked for again, and a
  // fetch that a branch is killing right now is not worth starting.
  assign w_data_pend  = DReqM & ~r_ddone;
  assign w_fetch_pend = IReqF & ~r_idone & ~FlushF;

`ifdef ARB_STARVE_GUARD_EN
  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);

  logic [RUN_W-1:0] r_run_cnt;

  assign w_force_fetch = w_fetch_pend & (r_run_cnt == RUN_W'(MAX_DATA_RUN));

  // Count data grants that overtook a waiting fetch; any fetch grant rearms.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_cnt <= '0;
    end else if (w_grant_fetch) begin
      r_run_cnt <= '0;
    end else if (w_grant_data && w_fetch_pend) begin
      r_run_cnt <= r_run_cnt + RUN_W'(1);
    end
  end
`else
  // Strict data priority: the run limit has no effect in this build.
  assign w_force_fetch = (MAX_DATA_RUN < 0);
`endif

  assign w_grant_data  = (r_state == IDLE) & w_data_pend & ~w_force_fetch;
  assign w_grant_fetch = (r_state == IDLE) & w_fetch_pend & ~w_grant_data;
  assign w_ack         = bus.BusAck & (r_state != IDLE);

  // Transaction sequencer: latch the winner's request in IDLE, hold it
  // stable on the bus until the slave acknowledges, then drop back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_stale     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_stale <= 1'b0;
          if (w_grant_data) begin
            r_state     <= DATA;
            r_bus_req   <= 1'b1;
            r_bus_we    <= DWeM;
            r_bus_addr  <= DAddrM;
            r_bus_wdata <= WriteDataM;
          end else if (w_grant_fetch) begin
            r_state    <= FETCH;
            r_bus_req  <= 1'b1;
            r_bus_we   <= 1'b0;
            r_bus_addr <= PCF;
          end
        end
        FETCH: begin
          // A branch in any cycle of the fetch makes its result useless.
          if (FlushF) begin
            r_stale <= 1'b1;
          end
          if (w_ack) begin
            r_state   <= IDLE;
            r_bus_req <= 1'b0;
          end
        end
        DATA: begin
          if (w_ack) begin
            r_state   <= IDLE;
            r_bus_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

  // Completion flags and captured read data for both requesters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ddone  <= 1'b0;
      r_drdata <= '0;
      r_idone  <= 1'b0;
      r_irdata <= '0;
    end else begin
      r_ddone <= (r_state == DATA) & w_ack;
      if ((r_state == DATA) && w_ack) begin
        r_drdata <= bus.BusRdata;
      end
      if ((r_state == FETCH) && w_ack && !r_stale && !FlushF) begin
        r_idone  <= 1'b1;
        r_irdata <= bus.BusRdata;
      end else if (FetchAdvF || FlushF) begin
        r_idone <= 1'b0;
      end
    end
  end

  assign bus.BusReq   = r_bus_req;
  assign bus.BusWe    = r_bus_we;
  assign bus.BusAddr  = r_bus_addr;
  assign bus.BusWdata = r_bus_wdata;

  assign IRdataF    = r_irdata;
  assign IValidF    = r_idone;
  assign DRdataM    = r_drdata;
  assign DValidM    = r_ddone;
  assign StallMem   = DReqM & ~r_ddone;
  assign StallFetch = IReqF & ~r_idone;

endmodule
